// File: rtl/fifo_prog_thr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_prog_thr
// Summary  : Synchronous FIFO with runtime almost-full/almost-empty thresholds,
//            optional first-word-fall-through read and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_prog_thr #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   umbral_high,
  input  logic [ADDR_WIDTH:0]   umbral_low,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int                c_depth    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_full_cnt = (ADDR_WIDTH+1)'(c_depth);

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow_err;
  logic                  r_underflow_err;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_cnt);
  // A pop frees a slot in the same edge, so a push on full rides along with it.
  assign w_rd_ok = rd_en & ~w_empty;
  assign w_wr_ok = wr_en & (~w_full | w_rd_ok);

  assign fifo_count    = r_count;
  assign empty         = w_empty;
  assign full          = w_full;
  assign almost_full   = (r_count >= umbral_high);
  assign almost_empty  = (r_count <= umbral_low);
  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error outranks err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (wr_en & ~w_wr_ok) begin
        r_overflow_err <= 1'b1;
      end else if (err_clr) begin
        r_overflow_err <= 1'b0;
      end
      if (rd_en & ~w_rd_ok) begin
        r_underflow_err <= 1'b1;
      end else if (err_clr) begin
        r_underflow_err <= 1'b0;
      end
    end
  end

  generate
    if (!FWFT) begin : g_std_read
      logic [DATA_WIDTH-1:0] r_data_out;
      logic                  r_valid_out;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data_out  <= '0;
          r_valid_out <= 1'b0;
        end else begin
          r_valid_out <= w_rd_ok;
          if (w_rd_ok) begin
            r_data_out <= r_mem[r_rd_ptr];
          end
        end
      end

      assign data_out  = r_data_out;
      assign valid_out = r_valid_out;
    end else begin : g_fwft_read
      // Head word is shown directly; forced to zero while nothing is stored.
      assign data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign valid_out = ~w_empty;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_prog_thr.sv
`default_nettype none
// Bench: six fifo_prog_thr instances (depth 4/8/16, standard and FWFT) share
// one stimulus stream and are compared every cycle against queue models.
module tb_fifo_prog_thr;

  localparam int NI = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       err_clr;
  logic [5:0] data_in;
  logic [4:0] uh [NI];
  logic [4:0] ul [NI];

  wire [5:0] dout_w [NI];
  wire [4:0] cnt_w  [NI];
  wire       vout_w [NI];
  wire       emp_w  [NI];
  wire       full_w [NI];
  wire       af_w   [NI];
  wire       ae_w   [NI];
  wire       ovf_w  [NI];
  wire       unf_w  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int AW = 2 + g % 3;
      wire [5:0]  dout;
      wire [AW:0] cnt;
      wire        vout, emp, fl, af, ae, ovf, unf;

      fifo_prog_thr #(
        .DATA_WIDTH(6),
        .ADDR_WIDTH(AW),
        .FWFT      (g >= 3)
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .umbral_high  (uh[g][AW:0]),
        .umbral_low   (ul[g][AW:0]),
        .err_clr      (err_clr),
        .data_out     (dout),
        .valid_out    (vout),
        .fifo_count   (cnt),
        .empty        (emp),
        .full         (fl),
        .almost_full  (af),
        .almost_empty (ae),
        .overflow_err (ovf),
        .underflow_err(unf)
      );

      assign dout_w[g] = dout;
      assign cnt_w[g]  = 5'(cnt);
      assign vout_w[g] = vout;
      assign emp_w[g]  = emp;
      assign full_w[g] = fl;
      assign af_w[g]   = af;
      assign ae_w[g]   = ae;
      assign ovf_w[g]  = ovf;
      assign unf_w[g]  = unf;
    end
  endgenerate

  // Reference model: contents as a queue, head at index 0.
  logic [5:0] q       [NI][$];
  logic [5:0] m_dout  [NI];
  logic       m_valid [NI];
  logic       m_ovf   [NI];
  logic       m_unf   [NI];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int dep(int i);
    return 1 << (2 + i % 3);
  endfunction

  function automatic bit is_fwft(int i);
    return i >= 3;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      m_dout[i]  = '0;
      m_valid[i] = 1'b0;
      m_ovf[i]   = 1'b0;
      m_unf[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int         sz;
      bit         rd_ok;
      bit         wr_ok;
      logic [5:0] v;
      sz    = q[i].size();
      rd_ok = rd_en && (sz > 0);
      wr_ok = wr_en && ((sz < dep(i)) || rd_ok);
      if (!is_fwft(i)) m_valid[i] = rd_ok;
      if (rd_ok) begin
        v = q[i].pop_front();
        if (!is_fwft(i)) m_dout[i] = v;
      end
      if (wr_ok) q[i].push_back(data_in);
      if (wr_en && !wr_ok) m_ovf[i] = 1'b1;
      else if (err_clr)    m_ovf[i] = 1'b0;
      if (rd_en && !rd_ok) m_unf[i] = 1'b1;
      else if (err_clr)    m_unf[i] = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      int sz;
      sz = q[i].size();
      chk("count", i, 32'(cnt_w[i]), 32'(sz));
      chk("empty", i, 32'(emp_w[i]), 32'(sz == 0));
      chk("full", i, 32'(full_w[i]), 32'(sz == dep(i)));
      chk("almost_full", i, 32'(af_w[i]), 32'(sz >= int'(uh[i])));
      chk("almost_empty", i, 32'(ae_w[i]), 32'(sz <= int'(ul[i])));
      chk("overflow_err", i, 32'(ovf_w[i]), 32'(m_ovf[i]));
      chk("underflow_err", i, 32'(unf_w[i]), 32'(m_unf[i]));
      if (is_fwft(i)) begin
        chk("valid_out", i, 32'(vout_w[i]), 32'(sz != 0));
        if (sz != 0) chk("data_out", i, 32'(dout_w[i]), 32'(q[i][0]));
      end else begin
        chk("valid_out", i, 32'(vout_w[i]), 32'(m_valid[i]));
        chk("data_out", i, 32'(dout_w[i]), 32'(m_dout[i]));
      end
    end
  endtask

  // Inputs are set just after a rising edge; the model consumes them before the next one.
  task automatic tick();
    if (!rst) model_step();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    compare_all();
  endtask

  task automatic drive(bit w, bit r, logic [5:0] d, bit c);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    err_clr = c;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    for (int i = 0; i < NI; i++) begin
      uh[i] = 5'(dep(i) - 2);
      ul[i] = 5'd2;
    end
    #1;
    model_reset();
    compare_all();
    chk("lit_reset_empty", 1, 32'(emp_w[1]), 32'd1);
    chk("lit_reset_count", 1, 32'(cnt_w[1]), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Fill to full, one rejected push, then drain in order.
    for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, 6'(k), 1'b0);
    chk("lit_full", 1, 32'(full_w[1]), 32'd1);
    chk("lit_count_full", 1, 32'(cnt_w[1]), 32'd8);
    chk("lit_no_ovf_yet", 1, 32'(ovf_w[1]), 32'd0);
    drive(1'b1, 1'b0, 6'd9, 1'b0);
    chk("lit_ovf_9th", 1, 32'(ovf_w[1]), 32'd1);
    chk("lit_count_after_9th", 1, 32'(cnt_w[1]), 32'd8);
    chk("lit_fwft_head", 4, 32'(dout_w[4]), 32'd1);
    for (int k = 10; k <= 16; k++) drive(1'b1, 1'b0, 6'(k), 1'b0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b1, 6'd0, 1'b0);
      if (k <= 8) chk("lit_pop_order", 1, 32'(dout_w[1]), 32'(k));
    end
    chk("lit_drained_empty", 1, 32'(emp_w[1]), 32'd1);
    drive(1'b0, 1'b0, 6'd0, 1'b1);

    // Simultaneous push/pop on full.
    for (int k = 1; k <= 16; k++) drive(1'b1, 1'b0, 6'(k), 1'b0);
    drive(1'b0, 1'b0, 6'd0, 1'b1);
    drive(1'b1, 1'b1, 6'h2A, 1'b0);
    chk("lit_swap_count", 1, 32'(cnt_w[1]), 32'd8);
    chk("lit_swap_data", 1, 32'(dout_w[1]), 32'h01);
    chk("lit_swap_no_ovf", 1, 32'(ovf_w[1]), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b1, 6'd0, 1'b0);
      if (k == 8) chk("lit_2a_last", 1, 32'(dout_w[1]), 32'h2A);
    end
    chk("lit_data_held", 1, 32'(dout_w[1]), 32'h2A);
    drive(1'b0, 1'b0, 6'd0, 1'b1);

    // Push+pop on empty.
    drive(1'b1, 1'b1, 6'h15, 1'b0);
    chk("lit_empty_pushpop_count", 1, 32'(cnt_w[1]), 32'd1);
    chk("lit_empty_pushpop_unf", 1, 32'(unf_w[1]), 32'd1);
    drive(1'b0, 1'b0, 6'd0, 1'b1);
    chk("lit_unf_cleared", 1, 32'(unf_w[1]), 32'd0);
    drive(1'b0, 1'b1, 6'd0, 1'b0);

    // Threshold sweep, plus a live threshold change at count 4.
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b0, 6'(k + 32), 1'b0);
      if (k == 2) chk("lit_ae_at_2", 1, 32'(ae_w[1]), 32'd1);
      if (k == 4) begin
        chk("lit_af_off_at_4", 1, 32'(af_w[1]), 32'd0);
        uh[1] = 5'd4;
        #1;
        chk("lit_af_live", 1, 32'(af_w[1]), 32'd1);
        compare_all();
        uh[1] = 5'd6;
      end
      if (k == 6) chk("lit_af_at_6", 1, 32'(af_w[1]), 32'd1);
    end
    for (int k = 1; k <= 16; k++) drive(1'b0, 1'b1, 6'd0, 1'b0);
    drive(1'b0, 1'b0, 6'd0, 1'b1);

    // FWFT fall-through and acknowledge.
    drive(1'b1, 1'b0, 6'h11, 1'b0);
    chk("lit_fwft_valid", 4, 32'(vout_w[4]), 32'd1);
    chk("lit_fwft_data", 4, 32'(dout_w[4]), 32'h11);
    drive(1'b0, 1'b1, 6'd0, 1'b0);
    chk("lit_fwft_empty", 4, 32'(emp_w[4]), 32'd1);
    chk("lit_fwft_novalid", 4, 32'(vout_w[4]), 32'd0);

    // Random traffic with alternating fill/drain bias and live threshold changes.
    for (int c = 0; c < 3000; c++) begin
      bit fill;
      fill = ((c / 150) % 2) == 0;
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < NI; i++) begin
          uh[i] = 5'($urandom_range(0, dep(i)));
          ul[i] = 5'($urandom_range(0, dep(i)));
        end
      end
      drive(($urandom_range(0, 99) < (fill ? 75 : 30)),
            ($urandom_range(0, 99) < (fill ? 30 : 75)),
            6'($urandom), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of traffic with count 5.
    for (int k = 1; k <= 16; k++) drive(1'b0, 1'b1, 6'd0, 1'b0);
    for (int k = 1; k <= 6; k++) drive(1'b1, 1'b0, 6'(k), 1'b0);
    drive(1'b0, 1'b1, 6'd0, 1'b0);
    chk("lit_pre_reset_count", 1, 32'(cnt_w[1]), 32'd5);
    chk("lit_pre_reset_valid", 1, 32'(vout_w[1]), 32'd1);
    chk("lit_pre_reset_ovf", 0, 32'(ovf_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("lit_rst_count", 1, 32'(cnt_w[1]), 32'd0);
    chk("lit_rst_empty", 1, 32'(emp_w[1]), 32'd1);
    chk("lit_rst_valid", 1, 32'(vout_w[1]), 32'd0);
    chk("lit_rst_ovf", 0, 32'(ovf_w[0]), 32'd0);
    chk("lit_rst_unf", 1, 32'(unf_w[1]), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 6'h05, 1'b0);
    drive(1'b0, 1'b1, 6'd0, 1'b0);
    chk("lit_after_reset_data", 1, 32'(dout_w[1]), 32'h05);
    drive(1'b0, 1'b0, 6'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
